iis_rx_core: RTL and testbench

I2S receive front-end, upstream of the APB IIS register block in the user plugin. Takes raw SCK/WS/SD pad inputs (async to clk_i) and deserialises standard-I2S stereo frames (MSB one SCK after WS edge). Delivers packed {left,right} samples through a small FIFO with valid/ready to the APB block, which reads them as register data and raises its interrupt.

---
 rtl/iis_pkg.sv | 24 ++
 rtl/iis_rx_fifo.sv | 74 +++++++
 rtl/iis_rx_core.sv | 216 +++++++++++++++++++++
 tb/tb_iis_rx_core.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/iis_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iis_pkg
//  Description : Shared types and constants for the I2S receive front-end.
//                - state_t : receiver state (IDLE / SYNC / RUN)
//                - frame_t : packed {left,right} frame at the default width
//                - c_sync_stages : flip-flop stages on each pad input
//  Revision    : 1.0 - initial release
// ============================================================================
package iis_pkg;

    localparam int c_sync_stages       = 2;
    localparam int c_default_data_width = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    typedef logic [2*c_default_data_width-1:0] frame_t;

endpackage : iis_pkg
`default_nettype wire

// File: rtl/iis_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : iis_rx_fifo
//  Description : Generic synchronous show-ahead FIFO. Pointers carry one
//                extra wrap bit so full and empty are distinguishable.
//                Ports:
//                  clk, rst_n      clock, asynchronous active-low reset
//                  i_flush         empties the FIFO (wins over push)
//                  i_push/i_push_data  write request and data
//                  i_pop           read request (ignored when empty)
//                  o_pop_data      head entry, zero when empty
//                  o_full/o_empty  status
//                  o_level         number of entries held
//  Revision    : 1.0 - initial release
// ============================================================================
module iis_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0]      r_wr_ptr;
    logic [c_aw:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic               w_empty;
    logic               w_full;
    logic               w_do_pop;
    logic               w_do_push;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_do_pop  = i_pop & ~w_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO succeeds.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr[c_aw-1:0]] <= i_push_data;
    end

    // Head is masked while empty so stale storage never reaches the output.
    assign o_pop_data = w_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_level    = r_wr_ptr - r_rd_ptr;

endmodule : iis_rx_fifo
`default_nettype wire

// File: rtl/iis_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : iis_rx_core
//  Description : I2S stereo receiver. Synchronises SCK/WS/SD pad inputs,
//                aligns to the start of a left word, deserialises MSB-first
//                words (truncated / zero-padded to DATA_WIDTH) and queues
//                {left,right} frames in a show-ahead FIFO.
//                Ports:
//                  clk_i, rst_n        clock, asynchronous active-low reset
//                  en_i                receiver enable
//                  sck_i, ws_i, sd_i   asynchronous I2S pad inputs
//                  sample_o            FIFO head {left,right}
//                  sample_valid_o      FIFO non-empty
//                  sample_ready_i      pop when valid & ready
//                  fifo_level_o        entries held
//                  overflow_o          sticky frame-dropped flag
//                  clr_ovf_i           clears overflow_o
//  Revision    : 1.0 - initial release
// ============================================================================
module iis_rx_core
    import iis_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_n,
    input  logic                           en_i,
    input  logic                           sck_i,
    input  logic                           ws_i,
    input  logic                           sd_i,
    output logic [2*DATA_WIDTH-1:0]        sample_o,
    output logic                           sample_valid_o,
    input  logic                           sample_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o,
    output logic                           overflow_o,
    input  logic                           clr_ovf_i
);

    localparam int                      c_cnt_w  = $clog2(DATA_WIDTH + 1);
    localparam logic [c_cnt_w-1:0]      c_cnt_max = c_cnt_w'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0]   c_msb    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // Pad synchronisers and SCK rising-edge detect
    // ------------------------------------------------------------------
    logic [c_sync_stages-1:0] r_sck_sync;
    logic [c_sync_stages-1:0] r_ws_sync;
    logic [c_sync_stages-1:0] r_sd_sync;
    logic                     r_sck_d;
    logic                     w_sck;
    logic                     w_ws;
    logic                     w_sd;
    logic                     w_sck_rise;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync <= '0;
            r_ws_sync  <= '0;
            r_sd_sync  <= '0;
            r_sck_d    <= 1'b0;
        end else begin
            r_sck_sync <= {r_sck_sync[c_sync_stages-2:0], sck_i};
            r_ws_sync  <= {r_ws_sync[c_sync_stages-2:0], ws_i};
            r_sd_sync  <= {r_sd_sync[c_sync_stages-2:0], sd_i};
            r_sck_d    <= w_sck;
        end
    end

    assign w_sck      = r_sck_sync[c_sync_stages-1];
    assign w_ws       = r_ws_sync[c_sync_stages-1];
    assign w_sd       = r_sd_sync[c_sync_stages-1];
    assign w_sck_rise = w_sck & ~r_sck_d;

    // WS seen at the previous SCK edge; the current bit belongs to it.
    logic r_ws_prev;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)          r_ws_prev <= 1'b0;
        else if (w_sck_rise) r_ws_prev <= w_ws;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_next;
    logic   w_clear;
    logic   w_align;
    logic   w_run_edge;
    logic   w_left_start;

    // Right-to-left WS transition: the edge carrying the right LSB.
    assign w_left_start = w_sck_rise & r_ws_prev & ~w_ws;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (!en_i) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_next = SYNC;
                SYNC:    if (w_left_start) w_state_next = RUN;
                RUN:     w_state_next = RUN;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_clear    = ~en_i;
        w_align    = en_i & (r_state == SYNC) & w_left_start;
        w_run_edge = en_i & (r_state == RUN) & w_sck_rise;
    end

    // ------------------------------------------------------------------
    // Deserialiser
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]   r_shreg;
    logic [c_cnt_w-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_left_hold;
    logic                    r_left_ok;
    logic                    r_push;
    logic [2*DATA_WIDTH-1:0] r_push_data;
    logic [DATA_WIDTH-1:0]   w_mask;
    logic [DATA_WIDTH-1:0]   w_shreg_next;

    // Mask walks from MSB down; once bit_cnt reaches DATA_WIDTH it is all
    // zero, which discards the excess bits of long words.
    assign w_mask       = c_msb >> r_bit_cnt;
    assign w_shreg_next = r_shreg | (w_sd ? w_mask : '0);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_left_hold <= '0;
            r_left_ok   <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else if (w_clear) begin
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_left_ok   <= 1'b0;
            r_push      <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (w_align) begin
                r_shreg   <= '0;
                r_bit_cnt <= '0;
                r_left_ok <= 1'b0;
            end else if (w_run_edge) begin
                if (w_ws != r_ws_prev) begin
                    if (!r_ws_prev) begin
                        r_left_hold <= w_shreg_next;
                        r_left_ok   <= 1'b1;
                    end else if (r_left_ok) begin
                        r_push_data <= {r_left_hold, w_shreg_next};
                        r_push      <= 1'b1;
                        r_left_ok   <= 1'b0;
                    end
                    r_shreg   <= '0;
                    r_bit_cnt <= '0;
                end else begin
                    r_shreg <= w_shreg_next;
                    if (r_bit_cnt != c_cnt_max) r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FIFO and overflow flag
    // ------------------------------------------------------------------
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_drop;
    logic r_overflow;

    assign w_pop  = sample_ready_i & ~w_empty;
    assign w_drop = r_push & w_full & ~w_pop & ~w_clear;

    iis_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*DATA_WIDTH)
    ) u_fifo (
        .clk         (clk_i),
        .rst_n       (rst_n),
        .i_flush     (w_clear),
        .i_push      (r_push),
        .i_push_data (r_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (sample_o),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (fifo_level_o)
    );

    // Set has priority over clear so a coincident drop is never lost.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)         r_overflow <= 1'b0;
        else if (w_drop)    r_overflow <= 1'b1;
        else if (clr_ovf_i) r_overflow <= 1'b0;
    end

    assign sample_valid_o = ~w_empty;
    assign overflow_o     = r_overflow;

endmodule : iis_rx_core
`default_nettype wire

// File: tb/tb_iis_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iis_rx_core
//  Description : Self-checking bench for iis_rx_core. Expected frames are
//                queued as stimulus is driven and compared as they are popped.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iis_rx_core;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_i  = 1'b0;
    logic        sck_i = 1'b0;
    logic        ws_i  = 1'b0;
    logic        sd_i  = 1'b0;
    logic [31:0] sample_o;
    logic        sample_valid_o;
    logic        sample_ready_i = 1'b0;
    logic [2:0]  fifo_level_o;
    logic        overflow_o;
    logic        clr_ovf_i = 1'b0;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    iis_rx_core #(
        .DATA_WIDTH (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_n          (rst_n),
        .en_i           (en_i),
        .sck_i          (sck_i),
        .ws_i           (ws_i),
        .sd_i           (sd_i),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .fifo_level_o   (fifo_level_o),
        .overflow_o     (overflow_o),
        .clr_ovf_i      (clr_ovf_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One SCK period of 8 clk_i cycles; data/WS change while SCK is low.
    // With do_pop set, ready is raised for exactly the cycle in which the
    // frame completed by this bit is written into the FIFO.
    task automatic send_bit(input logic ws, input logic sd, input logic do_pop);
        logic [31:0] e;
        @(negedge clk_i);
        sck_i = 1'b0;
        ws_i  = ws;
        sd_i  = sd;
        repeat (4) @(negedge clk_i);
        sck_i = 1'b1;
        repeat (3) @(negedge clk_i);
        if (do_pop) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
            check("head_before_cross", sample_o, e);
            check("level_before_cross", fifo_level_o, 4);
            sample_ready_i = 1'b1;
            @(negedge clk_i);
            sample_ready_i = 1'b0;
        end
    endtask

    // The LSB carries the opposite WS so the next word's MSB follows it.
    task automatic send_word(input logic ch, input logic [31:0] data, input int w);
        for (int i = w - 1; i >= 0; i--) send_bit((i == 0) ? ~ch : ch, data[i], 1'b0);
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        int          waited;
        waited = 0;
        while (!sample_valid_o && waited < 200) begin
            @(negedge clk_i);
            waited++;
        end
        check({tag, "_valid"}, sample_valid_o, 1'b1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
        check(tag, sample_o, e);
        sample_ready_i = 1'b1;
        @(negedge clk_i);
        sample_ready_i = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_sample", sample_o, 0);
        check("rst_valid", sample_valid_o, 0);
        check("rst_level", fifo_level_o, 0);
        check("rst_ovf", overflow_o, 0);
        repeat (3) @(negedge clk_i);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_i);
        en_i = 1'b1;
        repeat (3) @(negedge clk_i);

        // Partial right word then a 16-bit frame
        send_word(1'b1, 32'h15, 5);
        send_word(1'b0, 32'hA5C3, 16);
        send_word(1'b1, 32'h0F0F, 16);
        exp_q.push_back(32'hA5C3_0F0F);
        pop_check("frame16");
        repeat (2) @(negedge clk_i);
        check("single_frame_valid", sample_valid_o, 0);
        check("single_frame_level", fifo_level_o, 0);

        // Long words are truncated, short words zero-padded
        send_word(1'b0, 32'h123456, 24);
        send_word(1'b1, 32'hFEDCBA, 24);
        exp_q.push_back(32'h1234_FEDC);
        pop_check("frame24");
        send_word(1'b0, 32'hABC, 12);
        send_word(1'b1, 32'h123, 12);
        exp_q.push_back(32'hABC0_1230);
        pop_check("frame12");

        // Overflow: five frames, no consumer
        for (int k = 1; k <= 5; k++) begin
            send_word(1'b0, 32'h1000 + k, 16);
            send_word(1'b1, 32'h2000 + k, 16);
            if (k <= 4) exp_q.push_back({16'h1000 + 16'(k), 16'h2000 + 16'(k)});
        end
        repeat (4) @(negedge clk_i);
        check("ovf_level", fifo_level_o, 4);
        check("ovf_flag", overflow_o, 1);
        for (int k = 1; k <= 4; k++) pop_check("ovf_order");

        // Disable mid-left-word: flush, overflow retained, resync on re-enable
        send_word(1'b0, 32'h7777, 16);
        send_word(1'b1, 32'h8888, 16);
        repeat (4) @(negedge clk_i);
        check("pre_flush_level", fifo_level_o, 1);
        for (int i = 15; i >= 8; i--) send_bit(1'b0, 1'b1, 1'b0);
        en_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("flush_level", fifo_level_o, 0);
        check("flush_valid", sample_valid_o, 0);
        check("flush_ovf_kept", overflow_o, 1);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        en_i = 1'b1;
        for (int i = 5; i >= 0; i--) send_bit((i == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0);
        send_word(1'b1, 32'h5555, 16);
        repeat (4) @(negedge clk_i);
        check("no_partial_push", fifo_level_o, 0);
        send_word(1'b0, 32'hC0DE, 16);
        send_word(1'b1, 32'h1234, 16);
        exp_q.push_back(32'hC0DE_1234);
        pop_check("resync_frame");
        repeat (2) @(negedge clk_i);
        check("resync_level", fifo_level_o, 0);

        clr_ovf_i = 1'b1;
        @(negedge clk_i);
        clr_ovf_i = 1'b0;
        check("ovf_cleared", overflow_o, 0);

        // Full FIFO with a pop in the push cycle: no drop
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back({16'h3000 + 16'(k), 16'h4000 + 16'(k)});
            send_word(1'b0, 32'h3000 + k, 16);
            if (k < 5) begin
                send_word(1'b1, 32'h4000 + k, 16);
            end else begin
                for (int i = 15; i >= 1; i--) send_bit(1'b1, 1'(((32'h4000 + k) >> i) & 1), 1'b0);
                send_bit(1'b0, 1'((32'h4000 + k) & 1), 1'b1);
            end
        end
        repeat (4) @(negedge clk_i);
        check("cross_level", fifo_level_o, 4);
        check("cross_no_ovf", overflow_o, 0);
        for (int k = 2; k <= 5; k++) pop_check("cross_order");

        // Asynchronous reset mid-run
        send_word(1'b0, 32'hAAAA, 16);
        send_word(1'b1, 32'h5555, 16);
        send_bit(1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk_i);
        check("pre_rst_valid", sample_valid_o, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_sample", sample_o, 0);
        check("async_rst_valid", sample_valid_o, 0);
        check("async_rst_level", fifo_level_o, 0);
        check("async_rst_ovf", overflow_o, 0);
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_i);
        check("post_rst_level", fifo_level_o, 0);
        check("post_rst_valid", sample_valid_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_iis_rx_core
`default_nettype wire
